sdram_traffic_gen: RTL and testbench

Parametrised SDRAM traffic generator and checker that drives the sdram_controller user port (rw, rw_en, f_addr, f2s_data, f2s_data_valid, s2f_data, s2f_data_valid, ready).
- Issues full-page bursts over a programmable row/bank address range.
- Four selectable data patterns, optional timed (bandwidth) window with address wrap.
- Counts mismatches and captures the first failing location.
- Replaces the hard-coded board test FSM; board top keeps debounce/LED/BCD logic.

---
 rtl/sdram_traffic_gen.sv | 192 +++++++++++++++++++
 tb/tb_sdram_traffic_gen.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_traffic_gen.sv
// Burst traffic generator/checker for the sdram_controller user port.
// Writes or reads full pages over an address range and counts read mismatches.
module sdram_traffic_gen #(
  parameter int          ADDR_W        = 15,
  parameter int          DATA_W        = 16,
  parameter int          BURST_LEN     = 512,
  parameter int          IDX_W         = 10,
  parameter int unsigned WINDOW_CYCLES = 165_000_000,
  parameter int          CNT_W         = 37,
  parameter int          ERR_W         = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_write,
  input  logic              start_read,
  input  logic [1:0]        mode,
  input  logic              timed,
  input  logic [ADDR_W-1:0] addr_lo,
  input  logic [ADDR_W-1:0] addr_hi,
  input  logic              inject_err,
  input  logic              ready,
  input  logic              f2s_data_valid,
  input  logic [DATA_W-1:0] s2f_data,
  input  logic              s2f_data_valid,
  output logic              rw,
  output logic              rw_en,
  output logic [ADDR_W-1:0] f_addr,
  output logic [DATA_W-1:0] f2s_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic              first_err_valid,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [IDX_W-1:0]  first_err_index,
  output logic [CNT_W-1:0]  word_count,
  output logic [CNT_W-1:0]  cycle_count
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_BURST, RD_REQ, RD_BURST} state_t;

  localparam logic [DATA_W-1:0] CB_A = DATA_W'({DATA_W{2'b10}});

  state_t            r_state;
  logic [1:0]        r_mode;
  logic              r_timed;
  logic              r_inject;
  logic [ADDR_W-1:0] r_addr_lo;
  logic [ADDR_W-1:0] r_addr_hi;
  logic [ADDR_W-1:0] r_faddr;
  logic [IDX_W-1:0]  r_index;
  logic              r_done;
  logic              r_pass;
  logic [ERR_W-1:0]  r_err;
  logic              r_fev;
  logic [ADDR_W-1:0] r_fea;
  logic [IDX_W-1:0]  r_fei;
  logic [CNT_W-1:0]  r_word;
  logic [CNT_W-1:0]  r_cycle;

  logic [DATA_W-1:0] w_exp;
  logic              w_in_burst;
  logic              w_beat;
  logic              w_mismatch;
  logic              w_burst_end;
  logic              w_range_bad;
  logic              w_at_hi;
  logic              w_last;
  logic              w_inj_hit;
  logic [ADDR_W-1:0] w_next_addr;

  function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m,
                                                input logic [ADDR_W-1:0] a,
                                                input logic [IDX_W-1:0] i);
    logic [DATA_W-1:0] s;
    int unsigned       sh;
    s  = DATA_W'(a) + DATA_W'(i);
    sh = 32'(s) % DATA_W;
    case (m)
      2'd0:    return s;
      2'd1:    return DATA_W'(1) << sh;
      2'd2:    return ~s;
      default: return (a[0] ^ i[0]) ? CB_A : ~CB_A;
    endcase
  endfunction

  assign w_exp       = pattern(r_mode, r_faddr, r_index);
  assign w_in_burst  = (r_state == WR_BURST) || (r_state == RD_BURST);
  assign w_beat      = ((r_state == WR_BURST) && f2s_data_valid) ||
                       ((r_state == RD_BURST) && s2f_data_valid);
  assign w_mismatch  = (r_state == RD_BURST) && s2f_data_valid && (s2f_data != w_exp);
  assign w_burst_end = w_in_burst && (r_index == IDX_W'(BURST_LEN)) && !w_beat;
  // An inverted range degenerates to a single burst at addr_lo.
  assign w_range_bad = r_addr_hi < r_addr_lo;
  assign w_at_hi     = (r_faddr == r_addr_hi) || w_range_bad;
  assign w_last      = r_timed ? (r_cycle >= CNT_W'(WINDOW_CYCLES)) : w_at_hi;
  assign w_next_addr = w_at_hi ? r_addr_lo : r_faddr + 1'b1;
  assign w_inj_hit   = r_inject && (r_faddr == r_addr_lo);

  assign rw       = (r_state == RD_REQ) || (r_state == RD_BURST);
  assign rw_en    = ((r_state == WR_REQ) || (r_state == RD_REQ)) && ready;
  assign busy     = (r_state != IDLE);
  assign f2s_data = (r_state == WR_BURST) ? (w_exp ^ {{(DATA_W-1){1'b0}}, w_inj_hit}) : '0;

  assign f_addr          = r_faddr;
  assign done            = r_done;
  assign pass            = r_pass;
  assign err_count       = r_err;
  assign first_err_valid = r_fev;
  assign first_err_addr  = r_fea;
  assign first_err_index = r_fei;
  assign word_count      = r_word;
  assign cycle_count     = r_cycle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_mode    <= '0;
      r_timed   <= 1'b0;
      r_inject  <= 1'b0;
      r_addr_lo <= '0;
      r_addr_hi <= '0;
      r_faddr   <= '0;
      r_index   <= '0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_err     <= '0;
      r_fev     <= 1'b0;
      r_fea     <= '0;
      r_fei     <= '0;
      r_word    <= '0;
      r_cycle   <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state != IDLE && r_cycle != '1) r_cycle <= r_cycle + 1'b1;
      case (r_state)
        IDLE: begin
          if (start_write || start_read) begin
            r_mode    <= mode;
            r_timed   <= timed;
            r_addr_lo <= addr_lo;
            r_addr_hi <= addr_hi;
            r_faddr   <= addr_lo;
            r_inject  <= start_write && inject_err;
            r_word    <= '0;
            r_cycle   <= '0;
            r_state   <= start_write ? WR_REQ : RD_REQ;
            if (!start_write) begin
              r_err  <= '0;
              r_fev  <= 1'b0;
              r_fea  <= '0;
              r_fei  <= '0;
              r_pass <= 1'b0;
            end
          end
        end
        WR_REQ, RD_REQ: begin
          if (ready) begin
            r_index <= '0;
            r_state <= (r_state == WR_REQ) ? WR_BURST : RD_BURST;
          end
        end
        WR_BURST, RD_BURST: begin
          if (w_beat) begin
            r_index <= r_index + 1'b1;
            r_word  <= r_word + 1'b1;
          end
          if (w_mismatch) begin
            if (r_err != '1) r_err <= r_err + 1'b1;
            if (!r_fev) begin
              r_fev <= 1'b1;
              r_fea <= r_faddr;
              r_fei <= r_index;
            end
          end
          if (w_burst_end) begin
            if (w_last) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
              if (r_state == RD_BURST) r_pass <= (r_err == '0);
            end else begin
              r_faddr <= w_next_addr;
              r_state <= (r_state == WR_BURST) ? WR_REQ : RD_REQ;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_traffic_gen.sv
// Self-checking bench: behavioural controller/SDRAM model plus directed vector table.
module tb_sdram_traffic_gen;
  localparam int AW = 15, DW = 16, BL = 512, IW = 10, CW = 37, EW = 20;
  localparam int WIN = 5000;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_write, start_read, timed, inject_err;
  logic [1:0]    mode;
  logic [AW-1:0] addr_lo, addr_hi;
  logic          ready, f2s_data_valid, s2f_data_valid;
  logic [DW-1:0] s2f_data;
  logic          rw, rw_en, busy, done, pass, first_err_valid;
  logic [AW-1:0] f_addr, first_err_addr;
  logic [DW-1:0] f2s_data;
  logic [EW-1:0] err_count;
  logic [IW-1:0] first_err_index;
  logic [CW-1:0] word_count, cycle_count;

  always #5 clk = ~clk;

  sdram_traffic_gen #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .IDX_W(IW),
                      .WINDOW_CYCLES(WIN), .CNT_W(CW), .ERR_W(EW)) dut (
    .clk(clk), .rst(rst), .start_write(start_write), .start_read(start_read),
    .mode(mode), .timed(timed), .addr_lo(addr_lo), .addr_hi(addr_hi),
    .inject_err(inject_err), .ready(ready), .f2s_data_valid(f2s_data_valid),
    .s2f_data(s2f_data), .s2f_data_valid(s2f_data_valid), .rw(rw), .rw_en(rw_en),
    .f_addr(f_addr), .f2s_data(f2s_data), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_valid(first_err_valid),
    .first_err_addr(first_err_addr), .first_err_index(first_err_index),
    .word_count(word_count), .cycle_count(cycle_count));

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  function automatic logic [15:0] exp_pat(input logic [1:0] m, input logic [AW-1:0] a, input int i);
    logic [15:0] s;
    s = 16'(a) + 16'(i);
    case (m)
      2'd0:    return s;
      2'd1:    return 16'h0001 << s[3:0];
      2'd2:    return ~s;
      default: return (a[0] ^ i[0]) ? 16'hAAAA : 16'h5555;
    endcase
  endfunction

  // Controller + memory model, driven on the falling edge.
  logic [15:0]   mem [0:8191];
  int            c_ph = 0, c_cnt = 0;
  logic          c_rw;
  logic [AW-1:0] c_addr;
  logic [15:0]   m_exp;
  bit            stuck = 0;
  int            wr_beats = 0, wr_bad = 0;
  logic [1:0]    cur_mode = 0;
  logic          cur_inj = 0;
  logic [AW-1:0] cur_lo = 0;

  always @(negedge clk) begin
    if (rst) begin
      c_ph = 0; ready = 1'b1; f2s_data_valid = 1'b0; s2f_data_valid = 1'b0; s2f_data = '0;
    end else begin
      case (c_ph)
        0: if (rw_en) begin c_rw = rw; c_addr = f_addr; c_ph = 1; end
        1: begin ready = 1'b0; c_cnt = 0; c_ph = 2; end
        default: begin
          if (c_cnt < BL) begin
            if (!c_rw) begin
              f2s_data_valid = 1'b1;
              mem[{c_addr[3:0], c_cnt[8:0]}] = f2s_data;
              wr_beats++;
              m_exp = exp_pat(cur_mode, c_addr, c_cnt) ^ ((cur_inj && c_addr == cur_lo) ? 16'h1 : 16'h0);
              if (f2s_data !== m_exp) wr_bad++;
            end else begin
              s2f_data_valid = 1'b1;
              s2f_data = mem[{c_addr[3:0], c_cnt[8:0]}] & (stuck ? 16'hFFF7 : 16'hFFFF);
            end
            c_cnt++;
          end else begin
            f2s_data_valid = 1'b0; s2f_data_valid = 1'b0; ready = 1'b1; c_ph = 0;
          end
        end
      endcase
    end
  end

  logic [AW-1:0] addr_q[$];

  task automatic run(input bit wr, input bit rd, input logic [1:0] m, input bit tm,
                     input logic [AW-1:0] lo, input logic [AW-1:0] hi, input bit inj,
                     input int poke_rd, output int pulses, output int rw1,
                     output int dones, output int busy_n);
    @(negedge clk);
    mode = m; timed = tm; addr_lo = lo; addr_hi = hi; inject_err = inj;
    start_write = wr; start_read = rd;
    cur_mode = m; cur_inj = wr & inj; cur_lo = lo;
    wr_beats = 0; wr_bad = 0; addr_q.delete();
    @(negedge clk);
    start_write = 1'b0; start_read = 1'b0;
    pulses = 0; rw1 = 0; dones = 0; busy_n = 0;
    for (int cyc = 0; cyc < 20000 && dones == 0; cyc++) begin
      if (rw_en) begin pulses++; if (rw) rw1++; addr_q.push_back(f_addr); end
      if (busy) busy_n++;
      if (done) dones++;
      start_read = (cyc == poke_rd);
      if (dones == 0) @(negedge clk);
    end
    start_read = 1'b0;
    chk("run_completes", 64'(dones != 0), 64'd1);
    repeat (3) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("cycle_count_hold", cycle_count, 64'(busy_n));
    chk("idle_not_busy", 64'(busy), 64'd0);
    chk("idle_f2s_zero", 64'(f2s_data), 64'd0);
  endtask

  typedef struct {
    logic [1:0]    mode;
    logic [AW-1:0] lo, hi;
    bit            inj, stk;
    int            err, fa, fi, words, pulses;
  } vec_t;
  vec_t tbl [6];

  int pl, r1, dn, bn, bad;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start_write = 0; start_read = 0; mode = 0; timed = 0;
    addr_lo = 0; addr_hi = 0; inject_err = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 0);       chk("rst_rw_en", 64'(rw_en), 0);
    chk("rst_done", 64'(done), 0);       chk("rst_pass", 64'(pass), 0);
    chk("rst_err", err_count, 0);        chk("rst_faddr", f_addr, 0);
    chk("rst_f2s", f2s_data, 0);         chk("rst_words", word_count, 0);
    chk("rst_cycles", cycle_count, 0);   chk("rst_fev", 64'(first_err_valid), 0);

    tbl[0] = '{mode:2'd0, lo:0, hi:3, inj:0, stk:0, err:0,   fa:0, fi:0, words:2048, pulses:4};
    tbl[1] = '{mode:2'd0, lo:5, hi:7, inj:1, stk:0, err:512, fa:5, fi:0, words:1536, pulses:3};
    tbl[2] = '{mode:2'd0, lo:6, hi:4, inj:0, stk:0, err:0,   fa:0, fi:0, words:512,  pulses:1};
    tbl[3] = '{mode:2'd1, lo:2, hi:3, inj:0, stk:1, err:64,  fa:2, fi:1, words:1024, pulses:2};
    tbl[4] = '{mode:2'd2, lo:2, hi:3, inj:0, stk:1, err:512, fa:2, fi:0, words:1024, pulses:2};
    tbl[5] = '{mode:2'd3, lo:2, hi:3, inj:0, stk:1, err:512, fa:2, fi:1, words:1024, pulses:2};

    foreach (tbl[k]) begin
      stuck = 0;
      run(1, 0, tbl[k].mode, 0, tbl[k].lo, tbl[k].hi, tbl[k].inj, -1, pl, r1, dn, bn);
      chk("wr_beats", 64'(wr_beats), 64'(tbl[k].words));
      chk("wr_data", 64'(wr_bad), 0);
      chk("wr_words", word_count, 64'(tbl[k].words));
      chk("wr_pulses", 64'(pl), 64'(tbl[k].pulses));
      chk("wr_rw", 64'(r1), 0);
      chk("wr_done_pulse", 64'(dn), 1);
      chk("wr_first_addr", 64'(addr_q[0]), 64'(tbl[k].lo));
      stuck = tbl[k].stk;
      run(0, 1, tbl[k].mode, 0, tbl[k].lo, tbl[k].hi, 0, -1, pl, r1, dn, bn);
      chk("rd_err", err_count, 64'(tbl[k].err));
      chk("rd_pass", 64'(pass), 64'(tbl[k].err == 0));
      chk("rd_fev", 64'(first_err_valid), 64'(tbl[k].err != 0));
      chk("rd_fea", first_err_addr, 64'(tbl[k].fa));
      chk("rd_fei", first_err_index, 64'(tbl[k].fi));
      chk("rd_words", word_count, 64'(tbl[k].words));
      chk("rd_pulses", 64'(pl), 64'(tbl[k].pulses));
      chk("rd_rw", 64'(r1), 64'(tbl[k].pulses));
      chk("rd_done_pulse", 64'(dn), 1);
    end
    stuck = 0;

    // Timed window over 0..1 with wrap.
    run(1, 0, 2'd0, 1, 0, 1, 0, -1, pl, r1, dn, bn);
    bad = 0;
    foreach (addr_q[k]) if (addr_q[k] != AW'(k % 2)) bad++;
    chk("timed_wrap_seq", 64'(bad), 0);
    chk("timed_wrapped", 64'(pl >= 3), 1);
    chk("timed_words", word_count, 64'(pl * BL));
    chk("timed_min", 64'(cycle_count >= WIN), 1);
    chk("timed_max", 64'(cycle_count < WIN + BL + 16), 1);
    chk("timed_wr_data", 64'(wr_bad), 0);
    chk("timed_done_pulse", 64'(dn), 1);

    // Simultaneous starts: write wins.
    run(1, 1, 2'd0, 0, 4, 4, 0, -1, pl, r1, dn, bn);
    chk("both_rw", 64'(r1), 0);
    chk("both_beats", 64'(wr_beats), 512);
    chk("both_pulses", 64'(pl), 1);

    // start_read mid write burst is ignored.
    run(1, 0, 2'd0, 0, 4, 4, 0, 100, pl, r1, dn, bn);
    chk("busy_rd_rw", 64'(r1), 0);
    chk("busy_rd_pulses", 64'(pl), 1);
    chk("busy_rd_done", 64'(dn), 1);

    // Make err_count nonzero so the reset clear is observable.
    stuck = 1;
    run(0, 1, 2'd0, 0, 4, 4, 0, -1, pl, r1, dn, bn);
    chk("pre_rst_err", 64'(err_count != 0), 1);
    stuck = 0;

    // Reset during a write burst.
    @(negedge clk);
    mode = 0; timed = 0; addr_lo = 2; addr_hi = 3; inject_err = 0; start_write = 1;
    cur_mode = 0; cur_inj = 0; cur_lo = 2; wr_beats = 0;
    @(negedge clk);
    start_write = 0;
    for (int cyc = 0; cyc < 2000 && wr_beats < 100; cyc++) @(negedge clk);
    chk("mid_burst_reached", 64'(wr_beats >= 100 && f2s_data_valid), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_busy", 64'(busy), 0);        chk("mrst_rw", 64'(rw), 0);
    chk("mrst_rw_en", 64'(rw_en), 0);      chk("mrst_faddr", f_addr, 0);
    chk("mrst_f2s", f2s_data, 0);          chk("mrst_done", 64'(done), 0);
    chk("mrst_err", err_count, 0);         chk("mrst_fev", 64'(first_err_valid), 0);
    chk("mrst_fea", first_err_addr, 0);    chk("mrst_fei", first_err_index, 0);
    chk("mrst_words", word_count, 0);      chk("mrst_cycles", cycle_count, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run(1, 0, 2'd0, 0, 2, 2, 0, -1, pl, r1, dn, bn);
    chk("post_rst_wr_words", word_count, 512);
    run(0, 1, 2'd0, 0, 2, 2, 0, -1, pl, r1, dn, bn);
    chk("post_rst_err", err_count, 0);
    chk("post_rst_pass", 64'(pass), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
